// File: rtl/hyperram_arbiter.sv
// hyperram_arbiter
//   Round-robin arbiter sharing one hyperram controller between NUM_REQ
//   requesters. The winner's command and the current latency settings are
//   latched at grant, launched with a one-cycle ram_transaction_begin pulse,
//   timed for BASE_CYCLES + wait + done latency cycles, then acknowledged
//   with a one-cycle ack pulse. Read data is captured as the transaction ends.
//
// Ports
//   clk, rst                 system clock, asynchronous active-low reset
//   req/req_write            per-requester request (held until ack) and direction
//   req_address/req_wdata    packed 32-bit fields, requester i at [32i+31:32i]
//   req_wmask                packed 4-bit byte masks, requester i at [4i+3:4i]
//   cfg_wait/done_latency    latencies sampled at grant time
//   ack                      one-hot completion pulse
//   rdata                    read data of the last completed read
//   busy                     high whenever the arbiter is not idle
//   ram_*                    latched command towards the controller
//   ram_read_data            controller read data, valid at end of transaction
module hyperram_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned BASE_CYCLES = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_write,
    input  logic [NUM_REQ*32-1:0]   req_address,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    input  logic [NUM_REQ*4-1:0]    req_wmask,
    input  logic [5:0]              cfg_wait_latency,
    input  logic [5:0]              cfg_done_latency,
    output logic [NUM_REQ-1:0]      ack,
    output logic [31:0]             rdata,
    output logic                    busy,
    output logic                    ram_transaction_begin,
    output logic                    ram_write_enable,
    output logic [31:0]             ram_address,
    output logic [31:0]             ram_data_out,
    output logic [3:0]              ram_write_mask,
    output logic [5:0]              ram_wait_latency,
    output logic [5:0]              ram_done_latency,
    input  logic [31:0]             ram_read_data
);

    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEGIN,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               state;
    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        grant;
    logic [7:0]           counter;

    logic [GW-1:0]        winner;
    logic                 found;
    int unsigned          idx;
    logic                 sel_write;
    logic [31:0]          sel_address;
    logic [31:0]          sel_wdata;
    logic [3:0]           sel_wmask;
    logic [7:0]           n_cycles;
    logic [NUM_REQ-1:0]   grant_onehot;

    // Rotating priority: search starts just after the last served requester.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(last_grant) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                winner = GW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_write   = 1'b0;
        sel_address = '0;
        sel_wdata   = '0;
        sel_wmask   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == GW'(i)) begin
                sel_write   = req_write[i];
                sel_address = req_address[32*i +: 32];
                sel_wdata   = req_wdata[32*i +: 32];
                sel_wmask   = req_wmask[4*i +: 4];
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant == GW'(i)) begin
                grant_onehot[i] = 1'b1;
            end
        end
    end

    // Parameter range keeps this sum within 8 bits.
    assign n_cycles = 8'(BASE_CYCLES) + 8'(cfg_wait_latency) + 8'(cfg_done_latency);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= S_IDLE;
            last_grant            <= GW'(NUM_REQ - 1);
            grant                 <= '0;
            counter               <= '0;
            ack                   <= '0;
            rdata                 <= '0;
            busy                  <= 1'b0;
            ram_transaction_begin <= 1'b0;
            ram_write_enable      <= 1'b0;
            ram_address           <= '0;
            ram_data_out          <= '0;
            ram_write_mask        <= '0;
            ram_wait_latency      <= '0;
            ram_done_latency      <= '0;
        end else begin
            ram_transaction_begin <= 1'b0;
            ack                   <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant                 <= winner;
                        ram_write_enable      <= sel_write;
                        ram_address           <= sel_address;
                        ram_data_out          <= sel_wdata;
                        ram_write_mask        <= sel_wmask;
                        ram_wait_latency      <= cfg_wait_latency;
                        ram_done_latency      <= cfg_done_latency;
                        counter               <= n_cycles - 8'd1;
                        ram_transaction_begin <= 1'b1;
                        busy                  <= 1'b1;
                        state                 <= S_BEGIN;
                    end
                end
                S_BEGIN: begin
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    // Counter runs N-1..0, giving exactly N cycles in BUSY.
                    if (counter == 8'd0) begin
                        ack   <= grant_onehot;
                        if (!ram_write_enable) begin
                            rdata <= ram_read_data;
                        end
                        state <= S_DONE;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                S_DONE: begin
                    last_grant <= grant;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperram_arbiter.sv
module tb_hyperram_arbiter;

    localparam int NR = 4;
    localparam logic [31:0] RD_KEY = 32'hDEF8_8BA5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_write;
    logic [NR*32-1:0]  req_address;
    logic [NR*32-1:0]  req_wdata;
    logic [NR*4-1:0]   req_wmask;
    logic [5:0]        cfg_wait_latency;
    logic [5:0]        cfg_done_latency;
    logic [NR-1:0]     ack;
    logic [31:0]       rdata;
    logic              busy;
    logic              ram_transaction_begin;
    logic              ram_write_enable;
    logic [31:0]       ram_address;
    logic [31:0]       ram_data_out;
    logic [3:0]        ram_write_mask;
    logic [5:0]        ram_wait_latency;
    logic [5:0]        ram_done_latency;
    logic [31:0]       ram_read_data;

    hyperram_arbiter #(
        .NUM_REQ     (NR),
        .BASE_CYCLES (12)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req                   (req),
        .req_write             (req_write),
        .req_address           (req_address),
        .req_wdata             (req_wdata),
        .req_wmask             (req_wmask),
        .cfg_wait_latency      (cfg_wait_latency),
        .cfg_done_latency      (cfg_done_latency),
        .ack                   (ack),
        .rdata                 (rdata),
        .busy                  (busy),
        .ram_transaction_begin (ram_transaction_begin),
        .ram_write_enable      (ram_write_enable),
        .ram_address           (ram_address),
        .ram_data_out          (ram_data_out),
        .ram_write_mask        (ram_write_mask),
        .ram_wait_latency      (ram_wait_latency),
        .ram_done_latency      (ram_done_latency),
        .ram_read_data         (ram_read_data)
    );

    always #5 clk = ~clk;

    // Controller stand-in: read data is a fixed scramble of the address.
    assign ram_read_data = ram_address ^ RD_KEY;

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [5:0]  wl;
        logic [5:0]  dl;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_rdata;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          begin_cyc = 0;
    int          low_cnt = 0;
    bit          gap_armed = 0;
    bit          chk_gap = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_cmd(input int i, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask);
        req_write[i]            = wr;
        req_address[32*i +: 32] = addr;
        req_wdata[32*i +: 32]   = wdata;
        req_wmask[4*i +: 4]     = wmask;
    endtask

    task automatic push(input int i);
        exp_t e;
        e.id    = i;
        e.wr    = req_write[i];
        e.addr  = req_address[32*i +: 32];
        e.wdata = req_wdata[32*i +: 32];
        e.wmask = req_wmask[4*i +: 4];
        e.wl    = cfg_wait_latency;
        e.dl    = cfg_done_latency;
        if (!e.wr) model_rdata = e.addr ^ RD_KEY;
        e.rdata = model_rdata;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int i, input bit drop);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack[i] !== 1'b1 && n < 400);
        check($sformatf("ack_wait%0d", i), ack[i], 1);
        if (drop) req[i] = 1'b0;
    endtask

    // Output monitor / scoreboard consumer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy !== 1'b1) low_cnt++;
            if (ram_transaction_begin === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("beg_unexp", ram_transaction_begin, 0);
                end else begin
                    e = exp_q[0];
                    check("cmd_we",    ram_write_enable, e.wr);
                    check("cmd_addr",  ram_address,      e.addr);
                    check("cmd_wdata", ram_data_out,     e.wdata);
                    check("cmd_wmask", ram_write_mask,   e.wmask);
                    check("cmd_wl",    ram_wait_latency, e.wl);
                    check("cmd_dl",    ram_done_latency, e.dl);
                    check("beg_busy",  busy,             1);
                end
                if (gap_armed && chk_gap) check("idle_gap", low_cnt, 1);
                gap_armed = 0;
                begin_cyc = cyc;
            end
            if (ack !== '0) begin
                if (exp_q.size() == 0) begin
                    check("ack_unexp", ack, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack",       ack, 64'(1) << e.id);
                    check("rdata",     rdata, e.rdata);
                    check("ack_lat",   cyc - begin_cyc, 12 + int'(e.wl) + int'(e.dl) + 1);
                    check("hold_addr", ram_address, e.addr);
                    check("hold_wl",   ram_wait_latency, e.wl);
                end
                low_cnt   = 0;
                gap_armed = chk_gap;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req = '0;
        req_write = '0;
        req_address = '0;
        req_wdata = '0;
        req_wmask = '0;
        cfg_wait_latency = '0;
        cfg_done_latency = '0;
        model_rdata = '0;

        repeat (2) @(negedge clk);
        check("rst_ack",   ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy",  busy, 0);
        check("rst_beg",   ram_transaction_begin, 0);
        check("rst_cmd",   {ram_write_enable, ram_address, ram_data_out[15:0], ram_write_mask,
                            ram_wait_latency, ram_done_latency}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single read
        set_cmd(0, 1'b0, 32'h1234_5678, 32'h0BAD_0BAD, 4'hF);
        push(0);
        req[0] = 1'b1;
        @(negedge clk);
        check("beg_lat", ram_transaction_begin, 1);
        wait_ack(0, 1);
        @(negedge clk);

        // Single write with latencies; cfg changed mid-transaction
        set_cmd(2, 1'b1, 32'h0000_2000, 32'hCCCC_DDDD, 4'h0);
        cfg_wait_latency = 6'd6;
        cfg_done_latency = 6'd4;
        push(2);
        req[2] = 1'b1;
        repeat (4) @(negedge clk);
        cfg_wait_latency = 6'd1;
        cfg_done_latency = 6'd2;
        wait_ack(2, 1);
        @(negedge clk);

        // Round robin from reset, all held
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_rdata = '0;
        cfg_wait_latency = '0;
        cfg_done_latency = '0;
        set_cmd(0, 1'b0, 32'hA000_0000, 32'h1111_0000, 4'h1);
        set_cmd(1, 1'b1, 32'hA000_0010, 32'h2222_0000, 4'h3);
        set_cmd(2, 1'b0, 32'hA000_0020, 32'h3333_0000, 4'h7);
        set_cmd(3, 1'b0, 32'hA000_0030, 32'h4444_0000, 4'hF);
        push(0); push(1); push(2); push(3); push(0);
        chk_gap = 1;
        req = 4'hF;
        wait_ack(0, 0);
        wait_ack(1, 0);
        wait_ack(2, 0);
        wait_ack(3, 0);
        wait_ack(0, 0);
        req = '0;
        chk_gap = 0;
        repeat (2) @(negedge clk);

        // Fairness: req0 held, req2 raised during req0's BUSY
        set_cmd(0, 1'b0, 32'hB000_0100, 32'h5555_0000, 4'h2);
        set_cmd(2, 1'b1, 32'hB000_0200, 32'h6666_0000, 4'h4);
        cfg_done_latency = 6'd3;
        push(0);
        req[0] = 1'b1;
        repeat (4) @(negedge clk);
        push(2);
        push(0);
        req[2] = 1'b1;
        wait_ack(0, 0);
        wait_ack(2, 1);
        wait_ack(0, 1);
        repeat (2) @(negedge clk);

        // Requester drops req mid-BUSY
        cfg_done_latency = '0;
        set_cmd(1, 1'b0, 32'hC000_0004, 32'h7777_0000, 4'h8);
        push(1);
        req[1] = 1'b1;
        repeat (4) @(negedge clk);
        req[1] = 1'b0;
        wait_ack(1, 1);
        @(negedge clk);
        check("idle_busy", busy, 0);
        repeat (2) @(negedge clk);

        // Reset mid-BUSY
        set_cmd(1, 1'b1, 32'hD000_0008, 32'h8888_0000, 4'h5);
        push(1);
        req[1] = 1'b1;
        repeat (5) @(negedge clk);
        req[1] = 1'b0;
        rst = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_ack",  ack, 0);
        check("mrst_beg",  ram_transaction_begin, 0);
        check("mrst_cmd",  {ram_write_enable, ram_address, ram_data_out[15:0], ram_write_mask,
                            ram_wait_latency, ram_done_latency}, 0);
        exp_q.delete();
        model_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("mrst_idle", busy, 0);
        check("mrst_rdata", rdata, 0);
        set_cmd(3, 1'b0, 32'hE000_000C, 32'h9999_0000, 4'h6);
        push(3);
        req[3] = 1'b1;
        wait_ack(3, 1);
        repeat (3) @(negedge clk);
        check("q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
